input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//  Sits between the input pads and comp_core, and conditions the four raw active-low inputs:
//  nMode and nTrip (buttons), nFork (wheel sensor) and nCrank (pedal sensor).
//  Each input is synchronised through two flops, then debounced by a per-channel stability counter.
//  It produces single-cycle press pulses, debounced levels and, for the two buttons, a long-hold pulse.
//  The core consumes only clean, clock-domain-safe events.
// PARAMETERS
//  BTN_DB_CYCLES  164    consecutive stable cycles to accept a button change (~5 ms @ 32.768 kHz); >=2
//  SNS_DB_CYCLES  8      consecutive stable cycles to accept a fork/crank change; >=2
//  LONG_CYCLES    65536  cycles after a button press before its long pulse fires (2 s); >=2
// PORTS
//  Clock        in   1  system clock; all state on rising edge
//  nReset       in   1  asynchronous active-low reset
//  nMode_raw    in   1  raw pad level, 0 = pressed
//  nTrip_raw    in   1  raw pad level, 0 = pressed
//  nFork_raw    in   1  raw pad level, 0 = magnet present
//  nCrank_raw   in   1  raw pad level, 0 = magnet present
//  nMode_db     out  1  debounced level
//  nTrip_db     out  1  debounced level
//  nFork_db     out  1  debounced level
//  nCrank_db    out  1  debounced level
//  Mode_press   out  1  1-cycle pulse on debounced 1->0 of nMode
//  Trip_press   out  1  1-cycle pulse on debounced 1->0 of nTrip
//  Fork_pulse   out  1  1-cycle pulse on debounced 1->0 of nFork
//  Crank_pulse  out  1  1-cycle pulse on debounced 1->0 of nCrank
//  Mode_long    out  1  1-cycle pulse when nMode has been held LONG_CYCLES
//  Trip_long    out  1  1-cycle pulse when nTrip has been held LONG_CYCLES
// BEHAVIOUR
//  Reset (async, nReset=0)
//   - Sync flops and *_db = 1 (released); all pulses = 0; all counters = 0.
//   - Takes effect immediately, including mid-debounce or mid-hold; no pending event survives.
//  Synchroniser
//   - sync1 <= raw; sync2 <= sync1. sync2 is the only signal the debouncer sees.
//  Debounce, per channel, N = BTN_DB_CYCLES or SNS_DB_CYCLES
//   - sync2 == *_db: counter <= 0.
//   - sync2 != *_db and counter < N-1: counter increments.
//   - sync2 != *_db and counter == N-1: *_db <= sync2, counter <= 0.
//   - Any return of sync2 to *_db before acceptance restarts the count, so glitches shorter
//     than N cycles produce no output.
//   - Release (0->1) is debounced identically; it produces no pulse.
//  Press pulse
//   - Registered; high for exactly the cycle in which *_db has just become 0.
//   - Latency from the first edge sampling raw=0 to the pulse visible: N+2 rising edges.
//  Long hold (buttons only)
//   - Hold counter is cleared while *_db = 1 and counts cycles while *_db = 0.
//   - The *_long pulse fires once, LONG_CYCLES cycles after the *_press cycle.
//   - The counter then saturates, so there is no repeat until release and a new press.
//   - Release before LONG_CYCLES means no long pulse.
//  Concurrency
//   - All channels are fully independent; simultaneous events give same-cycle pulses.
//  Width rules
//   - Counter widths are $clog2(param)+1; there is no wrap in any counter.
// TESTING (bench overrides: BTN_DB=4, SNS_DB=3, LONG=20)
//  1. Assert nReset=0 with all raw inputs at 0 -> all *_db=1, all pulses 0; they stay so while reset is held.
//  2. nMode_raw 1->0, held -> Mode_press high for one cycle at edge 6, and nMode_db=0 from that edge.
//  3. nTrip_raw low for 3 cycles, then high; repeat 5 times -> no Trip_press, nTrip_db stays 1.
//  4. nTrip held low 40 cycles -> Trip_long is one cycle, 20 cycles after Trip_press, with no repeat.
//     Release, then re-press -> second Trip_press and second Trip_long.
//  5. nFork_raw and nCrank_raw fall on the same edge -> Fork_pulse and Crank_pulse both high at
//     edge 5, in the same cycle.
//  6. nMode low for 3 cycles, then pulse nReset, keep nMode low -> after release, Mode_press
//     appears only after a full 6 edges again.

Source files
------------

// File: rtl/input_conditioner_if.sv
// Pad-side bundle for input_conditioner: raw active-low inputs in, clean levels and pulses out.
interface input_conditioner_if;
  logic nMode_raw;
  logic nTrip_raw;
  logic nFork_raw;
  logic nCrank_raw;
  logic nMode_db;
  logic nTrip_db;
  logic nFork_db;
  logic nCrank_db;
  logic Mode_press;
  logic Trip_press;
  logic Fork_pulse;
  logic Crank_pulse;
  logic Mode_long;
  logic Trip_long;

  modport master (
    output nMode_raw, nTrip_raw, nFork_raw, nCrank_raw,
    input  nMode_db, nTrip_db, nFork_db, nCrank_db,
    input  Mode_press, Trip_press, Fork_pulse, Crank_pulse, Mode_long, Trip_long
  );

  modport slave (
    input  nMode_raw, nTrip_raw, nFork_raw, nCrank_raw,
    output nMode_db, nTrip_db, nFork_db, nCrank_db,
    output Mode_press, Trip_press, Fork_pulse, Crank_pulse, Mode_long, Trip_long
  );
endinterface

// File: rtl/input_conditioner.sv
// Synchronises and debounces the four active-low pad inputs, producing levels, press pulses and
// button long-hold pulses for comp_core.
module input_conditioner #(
  parameter int unsigned BTN_DB_CYCLES = 164,
  parameter int unsigned SNS_DB_CYCLES = 8,
  parameter int unsigned LONG_CYCLES   = 65536
) (
  input logic                Clock,
  input logic                nReset,
  input_conditioner_if.slave pads
);

  localparam int unsigned LongW = $clog2(LONG_CYCLES) + 1;
  localparam logic [LongW-1:0] LongLast = LongW'(LONG_CYCLES - 1);
  localparam logic [LongW-1:0] LongSat  = LongW'(LONG_CYCLES);

  logic [3:0] rawIn;
  logic [3:0] dbLevel;
  logic [3:0] pressPulse;
  logic [1:0] longPulse;

  // Channel order: 0 = Mode, 1 = Trip (buttons), 2 = Fork, 3 = Crank (sensors)
  assign rawIn = {pads.nCrank_raw, pads.nFork_raw, pads.nTrip_raw, pads.nMode_raw};

  assign pads.nMode_db    = dbLevel[0];
  assign pads.nTrip_db    = dbLevel[1];
  assign pads.nFork_db    = dbLevel[2];
  assign pads.nCrank_db   = dbLevel[3];
  assign pads.Mode_press  = pressPulse[0];
  assign pads.Trip_press  = pressPulse[1];
  assign pads.Fork_pulse  = pressPulse[2];
  assign pads.Crank_pulse = pressPulse[3];
  assign pads.Mode_long   = longPulse[0];
  assign pads.Trip_long   = longPulse[1];

  for (genvar g = 0; g < 4; g++) begin : gChan
    localparam int unsigned N    = (g < 2) ? BTN_DB_CYCLES : SNS_DB_CYCLES;
    localparam int unsigned CntW = $clog2(N) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    logic            sync1Q, sync2Q;
    logic            dbQ, dbD;
    logic            pulseQ, pulseD;
    logic [CntW-1:0] cntQ, cntD;

    // Count only while the synchronised level disagrees; any agreement restarts the window.
    always_comb begin
      cntD   = '0;
      dbD    = dbQ;
      pulseD = 1'b0;
      if (sync2Q != dbQ) begin
        if (cntQ == CntLast) begin
          dbD    = sync2Q;
          pulseD = ~sync2Q;
        end else begin
          cntD = cntQ + CntW'(1);
        end
      end
    end

    always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
        sync1Q <= 1'b1;
        sync2Q <= 1'b1;
        dbQ    <= 1'b1;
        pulseQ <= 1'b0;
        cntQ   <= '0;
      end else begin
        sync1Q <= rawIn[g];
        sync2Q <= sync1Q;
        dbQ    <= dbD;
        pulseQ <= pulseD;
        cntQ   <= cntD;
      end
    end

    assign dbLevel[g]    = dbQ;
    assign pressPulse[g] = pulseQ;
  end

  for (genvar h = 0; h < 2; h++) begin : gHold
    logic [LongW-1:0] holdQ, holdD;
    logic             longQ, longD;

    // Saturating at LONG_CYCLES makes the long pulse one-shot per press.
    always_comb begin
      holdD = holdQ;
      longD = 1'b0;
      if (dbLevel[h]) begin
        holdD = '0;
      end else if (holdQ != LongSat) begin
        holdD = holdQ + LongW'(1);
        longD = (holdQ == LongLast);
      end
    end

    always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
        holdQ <= '0;
        longQ <= 1'b0;
      end else begin
        holdQ <= holdD;
        longQ <= longD;
      end
    end

    assign longPulse[h] = longQ;
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: stimulus queues expected pulse cycles, a negedge
// monitor pops and compares whenever any pulse output is high.
module tb_input_conditioner;
  localparam int unsigned BtnDb   = 4;
  localparam int unsigned SnsDb   = 3;
  localparam int unsigned LongCyc = 20;

  logic Clock  = 1'b0;
  logic nReset = 1'b0;

  input_conditioner_if pads ();

  input_conditioner #(
    .BTN_DB_CYCLES(BtnDb),
    .SNS_DB_CYCLES(SnsDb),
    .LONG_CYCLES  (LongCyc)
  ) dut (
    .Clock (Clock),
    .nReset(nReset),
    .pads  (pads)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Index: 0 Mode_press, 1 Trip_press, 2 Fork_pulse, 3 Crank_pulse, 4 Mode_long, 5 Trip_long
  int    expQ[6][$];
  string names[6] = '{"Mode_press", "Trip_press", "Fork_pulse", "Crank_pulse",
                      "Mode_long", "Trip_long"};
  logic [5:0] pulses;
  assign pulses = {pads.Trip_long, pads.Mode_long, pads.Crank_pulse, pads.Fork_pulse,
                   pads.Trip_press, pads.Mode_press};

  int monExp;
  always @(negedge Clock) begin
    for (int i = 0; i < 6; i++) begin
      if (pulses[i]) begin
        checks++;
        if (expQ[i].size() == 0) begin
          failures++;
          $display("FAIL %s: unexpected pulse at cycle %0d, required none", names[i], cyc);
        end else begin
          monExp = expQ[i].pop_front();
          if (monExp != cyc) begin
            failures++;
            $display("FAIL %s: pulse at cycle %0d, required cycle %0d", names[i], cyc, monExp);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic checkLvl(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b, required %b at cycle %0d", name, act, exp, cyc);
    end
  endtask

  initial begin
    pads.nMode_raw  = 1'b0;
    pads.nTrip_raw  = 1'b0;
    pads.nFork_raw  = 1'b0;
    pads.nCrank_raw = 1'b0;

    // Reset held with all raw inputs pressed: levels stay released, no pulses
    for (int r = 0; r < 2; r++) begin
      idle(4);
      checkLvl("rst_nMode_db", pads.nMode_db, 1'b1);
      checkLvl("rst_nTrip_db", pads.nTrip_db, 1'b1);
      checkLvl("rst_nFork_db", pads.nFork_db, 1'b1);
      checkLvl("rst_nCrank_db", pads.nCrank_db, 1'b1);
    end
    checkLvl("rst_pulses_zero", |pulses, 1'b0);
    pads.nMode_raw  = 1'b1;
    pads.nTrip_raw  = 1'b1;
    pads.nFork_raw  = 1'b1;
    pads.nCrank_raw = 1'b1;
    idle(2);
    nReset = 1'b1;
    idle(8);

    // Mode press: pulse at edge BtnDb+2
    pads.nMode_raw = 1'b0;
    expQ[0].push_back(cyc + BtnDb + 2);
    idle(8);
    checkLvl("mode_db_pressed", pads.nMode_db, 1'b0);
    pads.nMode_raw = 1'b1;
    idle(10);
    checkLvl("mode_db_released", pads.nMode_db, 1'b1);

    // Trip glitches of 3 cycles never get accepted
    for (int r = 0; r < 5; r++) begin
      pads.nTrip_raw = 1'b0;
      idle(3);
      pads.nTrip_raw = 1'b1;
      idle(3);
      checkLvl("trip_glitch_db", pads.nTrip_db, 1'b1);
    end
    idle(6);

    // Trip long hold, twice
    for (int r = 0; r < 2; r++) begin
      pads.nTrip_raw = 1'b0;
      expQ[1].push_back(cyc + BtnDb + 2);
      expQ[5].push_back(cyc + BtnDb + 2 + LongCyc);
      idle(40);
      checkLvl("trip_db_held", pads.nTrip_db, 1'b0);
      pads.nTrip_raw = 1'b1;
      idle(10);
      checkLvl("trip_db_released", pads.nTrip_db, 1'b1);
    end

    // Fork and crank fall together
    pads.nFork_raw  = 1'b0;
    pads.nCrank_raw = 1'b0;
    expQ[2].push_back(cyc + SnsDb + 2);
    expQ[3].push_back(cyc + SnsDb + 2);
    idle(8);
    checkLvl("fork_db_low", pads.nFork_db, 1'b0);
    checkLvl("crank_db_low", pads.nCrank_db, 1'b0);
    pads.nFork_raw  = 1'b1;
    pads.nCrank_raw = 1'b1;
    idle(8);
    checkLvl("fork_db_high", pads.nFork_db, 1'b1);
    checkLvl("crank_db_high", pads.nCrank_db, 1'b1);

    // Reset mid-debounce discards progress; full latency applies after release
    pads.nMode_raw = 1'b0;
    idle(3);
    nReset = 1'b0;
    idle(1);
    checkLvl("mode_db_in_reset", pads.nMode_db, 1'b1);
    nReset = 1'b1;
    expQ[0].push_back(cyc + BtnDb + 2);
    expQ[4].push_back(cyc + BtnDb + 2 + LongCyc);
    idle(30);
    checkLvl("mode_db_after_reset", pads.nMode_db, 1'b0);
    pads.nMode_raw = 1'b1;
    idle(10);

    // Every expected pulse must have been seen
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (expQ[i].size() != 0) begin
        failures++;
        $display("FAIL %s: %0d expected pulses missing, required 0", names[i], expQ[i].size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
